// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable clock-enable generator.
//
// Each channel divides clk by a runtime-programmable divisor D. It emits a
// one-cycle tick every D+1 cycles and a 50 %-duty square wave clkd with
// period 2(D+1). Divisor and control registers share one
// address/din/writeEnable/dout bus.
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   address      [0] = 0 DIV / 1 CTRL, [ADDR_W-1:1] = channel number
//   din          write data
//   writeEnable  write strobe
//   dout         registered read data, refreshed every cycle
//   tick         per-channel one-cycle enable pulse
//   clkd         per-channel divided square wave
//
// Register map per channel
//   DIV  (rw)  write loads the shadow divisor; read returns the shadow divisor
//   CTRL (w)   bit0 enable, bit1 restart (self-clearing)
//   CTRL (r)   bit0 enable, bit2 shadow pending
//
// ADDR_W must be at least 2 so that the channel field is non-empty.
module tick_gen #(
    parameter int          CHANNELS    = 4,
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 32'd25_000,
    parameter int          ADDR_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [WIDTH-1:0]    din,
    input  logic                writeEnable,
    output logic [WIDTH-1:0]    dout,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clkd
);

    localparam int               CH_W    = ADDR_W - 1;
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1'b1);

    // Pack the CTRL read word: enable in bit0, pending in bit2.
    function automatic logic [WIDTH-1:0] ctrl_word(input logic en, input logic pend);
        logic [WIDTH-1:0] w;
        w    = '0;
        w[0] = en;
        w[2] = pend;
        return w;
    endfunction

    logic [CH_W-1:0]                chan_s;
    logic                           ctrl_sel_s;
    logic [CHANNELS-1:0][WIDTH-1:0] rd_word_s;
    logic [WIDTH-1:0]               rd_data_s;
    logic [WIDTH-1:0]               dout_r;

    assign chan_s     = address[ADDR_W-1:1];
    assign ctrl_sel_s = address[0];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(c);

        logic [WIDTH-1:0] ctr_r, div_act_r, div_shd_r;
        logic             en_r, pend_r, tick_r, clkd_r;
        logic [WIDTH-1:0] ctr_nx_s, div_act_nx_s, div_shd_nx_s;
        logic             en_nx_s, pend_nx_s, tick_nx_s, clkd_nx_s;
        logic             hit_s, div_wr_s, ctrl_wr_s, run_s, wrap_s;

        // Decode writes to this channel. A CTRL write changes the enable
        // that applies on the same edge, so a disable freezes the counter at
        // its current value.
        always_comb begin
            hit_s     = writeEnable && (chan_s == IDX);
            div_wr_s  = hit_s && !ctrl_sel_s;
            ctrl_wr_s = hit_s && ctrl_sel_s;
            if (ctrl_wr_s) begin
                run_s = din[0];
            end else begin
                run_s = en_r;
            end
            wrap_s = run_s && (ctr_r >= div_act_r);
        end

        // Next-state: restart beats wrap; a wrap picks up a same-cycle DIV
        // write directly so that the write never leaves a stale pending flag.
        always_comb begin
            ctr_nx_s     = ctr_r;
            div_act_nx_s = div_act_r;
            div_shd_nx_s = div_shd_r;
            en_nx_s      = en_r;
            pend_nx_s    = pend_r;
            tick_nx_s    = 1'b0;
            clkd_nx_s    = clkd_r;

            if (ctrl_wr_s) begin
                en_nx_s = din[0];
            end else begin
                en_nx_s = en_r;
            end

            if (div_wr_s) begin
                div_shd_nx_s = din;
            end else begin
                div_shd_nx_s = div_shd_r;
            end

            if (ctrl_wr_s && din[1]) begin
                ctr_nx_s     = '0;
                clkd_nx_s    = 1'b0;
                div_act_nx_s = div_shd_r;
                pend_nx_s    = 1'b0;
            end else if (wrap_s) begin
                ctr_nx_s  = '0;
                tick_nx_s = 1'b1;
                clkd_nx_s = ~clkd_r;
                pend_nx_s = 1'b0;
                if (div_wr_s) begin
                    div_act_nx_s = din;
                end else begin
                    div_act_nx_s = div_shd_r;
                end
            end else begin
                if (run_s) begin
                    ctr_nx_s = ctr_r + ONE;
                end else begin
                    ctr_nx_s = ctr_r;
                end
                if (div_wr_s) begin
                    pend_nx_s = 1'b1;
                end else begin
                    pend_nx_s = pend_r;
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctr_r     <= '0;
                div_act_r <= RST_DIV;
                div_shd_r <= RST_DIV;
                en_r      <= 1'b1;
                pend_r    <= 1'b0;
                tick_r    <= 1'b0;
                clkd_r    <= 1'b0;
            end else begin
                ctr_r     <= ctr_nx_s;
                div_act_r <= div_act_nx_s;
                div_shd_r <= div_shd_nx_s;
                en_r      <= en_nx_s;
                pend_r    <= pend_nx_s;
                tick_r    <= tick_nx_s;
                clkd_r    <= clkd_nx_s;
            end
        end

        assign tick[c]      = tick_r;
        assign clkd[c]      = clkd_r;
        assign rd_word_s[c] = ctrl_sel_s ? ctrl_word(en_r, pend_r) : div_shd_r;
    end

    // Read mux; a channel number with no channel behind it reads as zero.
    always_comb begin
        rd_data_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_s == CH_W'(c)) begin
                rd_data_s = rd_word_s[c];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Read data register, refreshed every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= '0;
        end else begin
            dout_r <= rd_data_s;
        end
    end

    assign dout = dout_r;

endmodule
